// File: rtl/qsys_mem_adapter_pkg.sv
// Shared types and default sizing for the on-chip memory burst adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qsys_mem_adapter_pkg;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 32;
    localparam int BURSTCOUNT_W = 4;
    localparam int MAX_BURST    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } state_e;

endpackage

// File: rtl/qsys_mem_rd_valid_pipe.sv
// Read-valid/data delay line aligning s_readdatavalid with RAM output data.
// Latency: 1 cycle, or 2 with ONCHIP_MEM_ADAPTER_RDREG_EN (RAM data re-registered).
// Backpressure: none; every issued read beat returns unconditionally.
module qsys_mem_rd_valid_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              s_readdatavalid,
    output logic [DATA_W-1:0] s_readdata
);

`ifdef ONCHIP_MEM_ADAPTER_RDREG_EN
    logic              vld1_q, vld1_d;
    logic              vld2_q, vld2_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    always_comb begin
        vld1_d = rd_issue;
        vld2_d = vld1_q;
        dat_d  = vld1_q ? m_readdata : dat_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            dat_q  <= dat_d;
        end
    end

    assign s_readdatavalid = vld2_q;
    assign s_readdata      = dat_q;
`else
    logic vld_q, vld_d;

    always_comb begin
        vld_d = rd_issue;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // RAM output is passed straight through, masked so reset and idle cycles read as zero.
    assign s_readdatavalid = vld_q;
    assign s_readdata      = vld_q ? m_readdata : '0;
`endif

endmodule

// File: rtl/qsys_onchip_mem_burst_adapter.sv
// Avalon-MM burst slave to single-port on-chip RAM; one RAM beat per cycle (macro ONCHIP_MEM_ADAPTER_RDREG_EN adds a read register).
// Latency: read data 1 cycle after each beat address (2 with the macro); writes land in the accepting cycle.
// Backpressure: waitrequest high only while a read burst is streaming; write bursts pace on s_write.
module qsys_onchip_mem_burst_adapter #(
    parameter int ADDR_W       = qsys_mem_adapter_pkg::ADDR_W,
    parameter int DATA_W       = qsys_mem_adapter_pkg::DATA_W,
    parameter int BURSTCOUNT_W = qsys_mem_adapter_pkg::BURSTCOUNT_W,
    parameter int MAX_BURST    = qsys_mem_adapter_pkg::MAX_BURST
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       s_address,
    input  logic [DATA_W/8-1:0]     s_byteenable,
    input  logic                    s_read,
    input  logic                    s_write,
    input  logic [DATA_W-1:0]       s_writedata,
    input  logic [BURSTCOUNT_W-1:0] s_burstcount,
    output logic                    s_waitrequest,
    output logic [DATA_W-1:0]       s_readdata,
    output logic                    s_readdatavalid,
    output logic [ADDR_W-1:0]       m_address,
    output logic [DATA_W/8-1:0]     m_byteenable,
    output logic [DATA_W-1:0]       m_writedata,
    output logic                    m_chipselect,
    output logic                    m_write,
    output logic                    m_clken,
    input  logic [DATA_W-1:0]       m_readdata
);

    import qsys_mem_adapter_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic [CNT_W-1:0]  n_acc;
    logic              cs, wr, waitreq;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        if (s_burstcount == '0) begin
            n_acc = CNT_W'(1);
        end else if (int'(s_burstcount) > MAX_BURST) begin
            n_acc = CNT_W'(MAX_BURST);
        end else begin
            n_acc = CNT_W'(s_burstcount);
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cs      = 1'b0;
        wr      = 1'b0;
        waitreq = 1'b0;
        addr    = base_q + ADDR_W'(cnt_q);
        unique case (state_q)
            IDLE: begin
                addr = s_address;
                // Write wins when both commands are presented together.
                if (s_write || s_read) begin
                    cs = 1'b1;
                    wr = s_write;
                    if (n_acc > CNT_W'(1)) begin
                        state_d = s_write ? WBURST : RBURST;
                        base_d  = s_address;
                        cnt_d   = CNT_W'(1);
                        len_d   = n_acc;
                    end
                end
            end
            RBURST: begin
                waitreq = 1'b1;
                cs      = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == len_q - CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            WBURST: begin
                if (s_write) begin
                    cs    = 1'b1;
                    wr    = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Strobes are masked by reset so a command held during reset never reaches the RAM.
    assign m_chipselect  = cs & reset_n;
    assign m_write       = wr & reset_n;
    assign s_waitrequest = waitreq & reset_n;
    assign m_address     = addr;
    assign m_byteenable  = s_byteenable;
    assign m_writedata   = s_writedata;
    assign m_clken       = 1'b1;

    qsys_mem_rd_valid_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk             (clk),
        .reset_n         (reset_n),
        .rd_issue        (cs & ~wr & reset_n),
        .m_readdata      (m_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_readdata      (s_readdata)
    );

endmodule

// File: tb/tb_qsys_onchip_mem_burst_adapter.sv
// Directed bench for qsys_onchip_mem_burst_adapter with a behavioural single-port RAM.
module tb_qsys_onchip_mem_burst_adapter;

`ifdef ONCHIP_MEM_ADAPTER_RDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_burstcount;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [14:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_chipselect;
    logic        m_write;
    logic        m_clken;
    logic [31:0] m_readdata;

    logic [31:0] ram     [0:32767];
    logic [31:0] exp_mem [0:32767];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qsys_onchip_mem_burst_adapter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_address       (s_address),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_burstcount    (s_burstcount),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    always @(posedge clk) begin
        if (m_chipselect && m_clken) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_byteenable[b]) ram[m_address][b*8 +: 8] <= m_writedata[b*8 +: 8];
                end
            end else begin
                m_readdata <= ram[m_address];
            end
        end
    end

    function automatic logic [31:0] pat(input logic [14:0] a);
        return (a == 15'h0010) ? 32'hDEADBEEF : (32'hA500_0000 ^ {17'h0, a});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic [14:0] a, input logic [3:0] bc,
                       input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        s_read       = rd;
        s_write      = wr;
        s_address    = a;
        s_burstcount = bc;
        s_writedata  = wd;
        s_byteenable = be;
        #1;
    endtask

    task automatic rd_burst(input logic [14:0] a, input logic [3:0] bc, input int n, input string tag);
        for (int i = 0; i <= n + LAT; i++) begin
            cyc(i == 0, 1'b0, a, bc, 32'h0, 4'h0);
            if (i < n) begin
                chk($sformatf("%s_cs%0d", tag, i), 64'(m_chipselect), 64'(1));
                chk($sformatf("%s_addr%0d", tag, i), 64'(m_address), 64'(15'(a + i)));
                chk($sformatf("%s_wr%0d", tag, i), 64'(m_write), 64'(0));
            end else begin
                chk($sformatf("%s_nocs%0d", tag, i), 64'(m_chipselect), 64'(0));
            end
            chk($sformatf("%s_wait%0d", tag, i), 64'(s_waitrequest), 64'(i >= 1 && i < n));
            chk($sformatf("%s_vld%0d", tag, i), 64'(s_readdatavalid), 64'(i >= LAT && i < n + LAT));
            if (i >= LAT && i < n + LAT)
                chk($sformatf("%s_dat%0d", tag, i), 64'(s_readdata), 64'(exp_mem[15'(a + i - LAT)]));
        end
    endtask

    initial begin
        for (int k = 0; k < 32768; k++) begin
            ram[k]     = pat(15'(k));
            exp_mem[k] = pat(15'(k));
        end
        reset_n = 1'b0;
        s_read = 1'b0; s_write = 1'b0; s_address = '0; s_burstcount = '0;
        s_writedata = '0; s_byteenable = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cs", 64'(m_chipselect), 64'(0));
        chk("rst_wr", 64'(m_write), 64'(0));
        chk("rst_vld", 64'(s_readdatavalid), 64'(0));
        chk("rst_dat", 64'(s_readdata), 64'(0));
        chk("rst_wait", 64'(s_waitrequest), 64'(0));
        chk("clken", 64'(m_clken), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;

        rd_burst(15'h0010, 4'd1, 1, "single");
        rd_burst(15'h7FFE, 4'd8, 8, "wrap8");
        rd_burst(15'h0020, 4'd0, 1, "bc0");
        rd_burst(15'h0030, 4'd15, 8, "bc15");

        // Write burst of 4 with a gap after beat 1; the read held in the gap must be ignored.
        cyc(1'b0, 1'b1, 15'h0100, 4'd4, 32'h1111_1111, 4'hF);
        chk("wb0_cs", 64'(m_chipselect), 64'(1));
        chk("wb0_wr", 64'(m_write), 64'(1));
        chk("wb0_addr", 64'(m_address), 64'(15'h0100));
        cyc(1'b0, 1'b1, 15'h7000, 4'd1, 32'h5555_5555, 4'hF);
        chk("wb1_addr", 64'(m_address), 64'(15'h0101));
        chk("wb1_dat", 64'(m_writedata), 64'(32'h5555_5555));
        cyc(1'b1, 1'b0, 15'h7000, 4'd1, 32'h0, 4'h0);
        chk("wgap_cs", 64'(m_chipselect), 64'(0));
        chk("wgap_wait", 64'(s_waitrequest), 64'(0));
        cyc(1'b0, 1'b1, 15'h7000, 4'd1, 32'h2222_2222, 4'h3);
        chk("wb2_addr", 64'(m_address), 64'(15'h0102));
        chk("wb2_be", 64'(m_byteenable), 64'(4'h3));
        chk("wb2_wr", 64'(m_write), 64'(1));
        cyc(1'b0, 1'b1, 15'h7000, 4'd1, 32'h3333_3333, 4'hF);
        chk("wb3_addr", 64'(m_address), 64'(15'h0103));
        chk("wb3_cs", 64'(m_chipselect), 64'(1));
        exp_mem[15'h0100] = 32'h1111_1111;
        exp_mem[15'h0101] = 32'h5555_5555;
        exp_mem[15'h0102] = 32'hA500_2222;
        exp_mem[15'h0103] = 32'h3333_3333;
        rd_burst(15'h0100, 4'd4, 4, "wrback");

        // Simultaneous read and write: write serviced, read dropped.
        cyc(1'b1, 1'b1, 15'h0060, 4'd1, 32'hCAFE_F00D, 4'hF);
        chk("rw_cs", 64'(m_chipselect), 64'(1));
        chk("rw_wr", 64'(m_write), 64'(1));
        exp_mem[15'h0060] = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 15'h0, 4'd0, 32'h0, 4'h0);
            chk($sformatf("rw_novld%0d", i), 64'(s_readdatavalid), 64'(0));
        end
        rd_burst(15'h0060, 4'd1, 1, "rwback");

        // Reset in the middle of an 8-beat read.
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0, 1'b0, 15'h0200, 4'd8, 32'h0, 4'h0);
            chk($sformatf("rr_addr%0d", i), 64'(m_address), 64'(15'h0200 + 15'(i)));
        end
        reset_n = 1'b0;
        #1;
        chk("rr_cs", 64'(m_chipselect), 64'(0));
        chk("rr_wr", 64'(m_write), 64'(0));
        chk("rr_vld", 64'(s_readdatavalid), 64'(0));
        chk("rr_dat", 64'(s_readdata), 64'(0));
        chk("rr_wait", 64'(s_waitrequest), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 15'h0, 4'd0, 32'h0, 4'h0);
            chk($sformatf("rr_post_cs%0d", i), 64'(m_chipselect), 64'(0));
            chk($sformatf("rr_post_vld%0d", i), 64'(s_readdatavalid), 64'(0));
        end
        rd_burst(15'h0300, 4'd2, 2, "rrnext");

        // Back-to-back read(2) then write(1) with no bubble.
        cyc(1'b1, 1'b0, 15'h0040, 4'd2, 32'h0, 4'h0);
        chk("b2b_cs0", 64'(m_chipselect), 64'(1));
        cyc(1'b0, 1'b0, 15'h0040, 4'd2, 32'h0, 4'h0);
        chk("b2b_wait1", 64'(s_waitrequest), 64'(1));
        chk("b2b_addr1", 64'(m_address), 64'(15'h0041));
        cyc(1'b0, 1'b1, 15'h0050, 4'd1, 32'h1234_5678, 4'hF);
        chk("b2b_wait2", 64'(s_waitrequest), 64'(0));
        chk("b2b_wr2", 64'(m_write), 64'(1));
        chk("b2b_addr2", 64'(m_address), 64'(15'h0050));
        chk("b2b_vld2", 64'(s_readdatavalid), 64'(LAT == 1));
        exp_mem[15'h0050] = 32'h1234_5678;
        cyc(1'b0, 1'b0, 15'h0, 4'd0, 32'h0, 4'h0);
        chk("b2b_idle_cs", 64'(m_chipselect), 64'(0));
        rd_burst(15'h0050, 4'd1, 1, "b2bback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qsys_onchip_mem_burst_adapter.md
QSYS_ONCHIP_MEM_BURST_ADAPTER -- requirements
Module: qsys_onchip_mem_burst_adapter

Interface
REQ-001 Parameter ADDR_W, default 15, gives the word-address width on both sides.
REQ-002 Parameter DATA_W, default 32, gives the data width; byteenable width is DATA_W/8.
REQ-003 Parameter BURSTCOUNT_W, default 4, gives the burstcount field width.
REQ-004 Parameter MAX_BURST, default 8, gives the largest serviced burst length.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 s_address  in  ADDR_W  Avalon-MM slave word address (burst base).
REQ-008 s_byteenable  in  DATA_W/8  byte lanes for the current write beat.
REQ-009 s_read  in  1  read command.
REQ-010 s_write  in  1  write command / write beat.
REQ-011 s_writedata  in  DATA_W  write data for the current beat.
REQ-012 s_burstcount  in  BURSTCOUNT_W  beats in the burst, sampled only on command acceptance.
REQ-013 s_waitrequest  out  1  stall; a command or beat is accepted only when this is low.
REQ-014 s_readdata  out  DATA_W  read data.
REQ-015 s_readdatavalid  out  1  s_readdata qualifier, one pulse per read beat.
REQ-016 m_address, m_byteenable, m_writedata  out  ADDR_W, DATA_W/8, DATA_W  to the single-port RAM.
REQ-017 m_chipselect, m_write, m_clken  out  1 each  RAM access strobe, write strobe, clock enable.
REQ-018 m_readdata  in  DATA_W  RAM output, valid one cycle after the address is presented.

Function
REQ-019 The FSM SHALL have states IDLE, RBURST, WBURST.
REQ-020 s_waitrequest SHALL be low in IDLE and WBURST and high in RBURST.
REQ-021 An effective burst length N SHALL be derived at acceptance: burstcount 0 gives N=1; values above MAX_BURST clamp to MAX_BURST.
REQ-022 A read accepted in IDLE at cycle t SHALL issue beat i (m_chipselect=1, m_write=0, m_address=base+i) at cycle t+i, for i=0..N-1.
REQ-023 The FSM SHALL occupy RBURST for cycles t+1..t+N-1 and return to IDLE at t+N; N=1 stays in IDLE.
REQ-024 s_readdatavalid SHALL be high at cycles t+1..t+N, with s_readdata=m_readdata.
REQ-025 A write accepted in IDLE SHALL write beat 0 in the same cycle at base and enter WBURST when N>1.
REQ-026 In WBURST, each cycle with s_write=1 SHALL write one beat at base+k with the current byteenable and data; cycles with s_write=0 SHALL issue no access and leave k unchanged.
REQ-027 After beat N-1 is written, the FSM SHALL return to IDLE on the next cycle.
REQ-028 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-029 If s_read and s_write are both high in IDLE, the write SHALL be serviced and the read SHALL be discarded.
REQ-030 s_read SHALL be ignored while in WBURST.
REQ-031 m_clken SHALL be constant 1.
REQ-032 m_chipselect SHALL be low on every cycle without an issued beat.
REQ-033 A new command SHALL be accepted in the cycle the FSM re-enters IDLE, giving zero-bubble back-to-back bursts.

Reset
REQ-034 On reset_n low, the block SHALL asynchronously enter IDLE and clear the beat counter, base register and read-valid pipeline.
REQ-035 During reset: s_readdatavalid=0, s_readdata=0, m_chipselect=0, m_write=0, s_waitrequest=0.
REQ-036 A burst interrupted by reset SHALL be abandoned, with no further beats or valids after reset release.

Configuration
REQ-037 With ONCHIP_MEM_ADAPTER_RDREG_EN defined, m_readdata SHALL be registered, so read valids occur at t+2..t+N+1 and reset clears the data register.
REQ-038 Without ONCHIP_MEM_ADAPTER_RDREG_EN, read latency SHALL be exactly one cycle, as in REQ-024.

Structure
REQ-039 Package qsys_mem_adapter_pkg SHALL hold the state enum and the default constants ADDR_W, DATA_W, BURSTCOUNT_W and MAX_BURST.
REQ-040 Sub-module qsys_mem_rd_valid_pipe SHALL implement the valid and data delay line, depth 1 or 2 according to the macro.

Verification
REQ-041 Single read, burstcount=1, addr 0x0010, RAM word 0xDEADBEEF -> one valid at t+1 with 0xDEADBEEF; waitrequest never high.
REQ-042 Read burst of 8 at 0x7FFE -> m_address 7FFE,7FFF,0000..0005; 8 valids at t+1..t+8; waitrequest high t+1..t+7.
REQ-043 Write burst of 4 at 0x0100 with an s_write=0 gap after beat 1 -> writes at 0x100..0x103 and no access in the gap cycle; readback matches.
REQ-044 burstcount=0 and burstcount=15 -> exactly 1 and 8 beats respectively.
REQ-045 reset_n pulsed low at beat 3 of an 8-beat read -> outputs go to reset values immediately; no valids after release; next read completes normally.
REQ-046 Back-to-back read(N=2) then write(N=1) -> write accepted in the cycle of the second valid, with no idle bubble.
